dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
- Parametrised successor of the single-bit DFF: a WIDTH-bit, DEPTH-stage elastic register pipeline with a valid/ready handshake on both sides.
- Each stage is a data register plus a valid bit.
- A stage advances only when the next stage can accept, so backpressure stalls the pipeline without losing data.
- Used as a retiming/buffering element between producer and consumer blocks in the verification designs, driven through an interface like the existing DFF.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); also the maximum number of items held.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  pipeline can accept this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  WIDTH  output word (stage DEPTH-1).
- flush  input  1  synchronous clear of all valid bits.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (rst=0, asynchronous): all valid bits=0, all data registers=0. Outputs: out_valid=0, out_data=0, count=0. in_ready follows the combinational rule below: it is 1 after reset, with flush low.
- Per-stage advance rule, for k=0..DEPTH-1: adv[k] = !valid[k] | adv[k+1], with adv[DEPTH] = out_ready.
- in_ready = adv[0] & !flush.
- Combinational ready chain, no skid buffer.
- out_valid = valid[DEPTH-1] & !flush.
- out_data = data[DEPTH-1].
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
- On each posedge clk (rst=1, flush=0), for each stage k where adv[k]=1:
  - Stage 0: valid[0] <= in_valid; data[0] <= in_data when in_valid=1.
  - Stage k>0: valid[k] <= valid[k-1]; data[k] <= data[k-1] when valid[k-1]=1.
  - Otherwise data[k] holds its value; bubbles never overwrite data.
- Stalled stage (adv[k]=0): valid and data hold.
- Latency: item accepted at edge N appears on out_valid after edge N+DEPTH-1 with no stall; i.e. DEPTH cycles accept-to-visible, counting the accept edge.
- Throughput: 1 item/cycle when out_ready is held 1.
- Full (all DEPTH valid) with out_ready=1: simultaneous accept and emit; in_ready=1; count unchanged.
- Full with out_ready=0: in_ready=0; nothing moves.
- Empty: out_valid=0; out_data holds the last value.
- Bubbles: a bubble in stage k collapses when downstream stalls, because upstream stages still advance into it.
- flush=1:
  - in_ready=0 and out_valid=0, so no transfers occur.
  - At the edge, all valid <= 0; data unchanged.
  - count=0 the cycle after.
- count: registered; equals the popcount of valid bits. Recompute it from next-state valid bits, not by increment/decrement.
- rst asserted mid-stream: all items are discarded immediately. On deassertion, the block starts empty.
- rst deassertion is expected synchronous to clk, via an external synchroniser.

Optional Feature:
- Macro DFF_PIPE_STATS_EN.
- When defined:
  - Adds output stall_cnt (16 bits), reset to 0 by rst.
  - stall_cnt increments on each posedge where out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by flush.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst=0 mid-cycle with clk stopped -> out_valid=0, out_data=0, count=0 immediately; in_ready=1 after release.
- Streaming (WIDTH=8, DEPTH=3, out_ready=1): send 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> out_data 11,22,33,44 on consecutive cycles, first appearing 3 cycles after the first accept; count peaks at 3.
- Backpressure: hold out_ready=0 and send 8'hA0..A4 -> exactly 3 accepted; in_ready=0 from then on; count=3. Release out_ready -> A0, A1, A2 emerge in order, A3 and A4 then accepted, no loss or duplicates.
- Simultaneous full accept/emit: pipeline full, in_valid=1, out_ready=1 for 5 cycles -> in_ready=1 throughout, count stays 3, order preserved.
- Flush: pipeline holding 2 items, pulse flush=1 for 1 cycle with in_valid=1 -> in_ready=0 and out_valid=0 that cycle; count=0 next cycle; the flushed items never appear on the output.
- Stats (DFF_PIPE_STATS_EN): full pipeline with out_ready=0 for 10 cycles -> stall_cnt=10; flush -> stall_cnt=0.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline with a valid/ready
// handshake on both sides. The ready chain is combinational, with no skid buffer.
// A stage advances only when the stage below it can accept, so backpressure
// stalls the pipe without losing data, and bubbles collapse under a stall.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   in_valid   producer presents in_data
//   in_ready   pipeline can accept this cycle (combinational)
//   in_data    input word
//   out_valid  out_data is valid (combinational from the last valid bit)
//   out_ready  consumer accepts this cycle
//   out_data   output word (last stage)
//   flush      synchronous clear of all valid bits
//   count      registered number of valid stages
//   stall_cnt  saturating count of stalled output cycles (DFF_PIPE_STATS_EN only)
//
// Optional feature macro: DFF_PIPE_STATS_EN adds the stall_cnt output.
module dff_pipe #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
`ifdef DFF_PIPE_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH:0]   adv;
    logic [CW-1:0]    cnt_nxt;
    logic             acc;

    // Advance chain: stage k may move when it or any stage below it is empty,
    // or when the consumer takes the last word.
    always_comb begin
        acc        = out_ready;
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            acc    = acc | ~valid[k];
            adv[k] = acc;
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = valid[DEPTH-1] & ~flush;
    assign out_data  = data[DEPTH-1];

    // Next-state valid bits and their popcount.
    always_comb begin
        valid_nxt = valid;
        if (flush) begin
            valid_nxt = '0;
        end else begin
            if (adv[0]) valid_nxt[0] = in_valid;
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (adv[k]) valid_nxt[k] = valid[k-1];
            end
        end
        cnt_nxt = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            cnt_nxt = cnt_nxt + CW'(valid_nxt[k]);
        end
    end

    // Valid bits and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= valid_nxt;
            count <= cnt_nxt;
        end
    end

    // Data registers load only from a valid upstream word, so bubbles never
    // overwrite data and an empty pipe keeps presenting the last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) data[k] <= '0;
        end else if (!flush) begin
            if (adv[0] && in_valid) data[0] <= in_data;
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (adv[k] && valid[k-1]) data[k] <= data[k-1];
            end
        end
    end

`ifdef DFF_PIPE_STATS_EN
    // Saturating count of cycles where the output word was refused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=3). A scoreboard queue
// holds every accepted word; each output transfer pops and compares, and the
// registered count is checked against the queue occupancy after every edge.
module tb_dff_pipe;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic [1:0] count;
`ifdef DFF_PIPE_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic       last_in_xfer;
    int         idx;

    dff_pipe #(.WIDTH(8), .DEPTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count)
`ifdef DFF_PIPE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, update the scoreboard,
    // then return at the next negedge and check occupancy.
    task automatic tick();
        logic       in_x;
        logic       out_x;
        logic [7:0] e;
        #1;
        in_x  = in_valid & in_ready;
        out_x = out_valid & out_ready;
        if (out_x) begin
            if (exp_q.size() == 0) begin
                chk("pop_empty", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e));
            end
        end
        if (in_x) exp_q.push_back(in_data);
        if (flush) exp_q.delete();
        last_in_xfer = in_x;
        @(posedge clk);
        @(negedge clk);
        chk("count", 32'(count), 32'(exp_q.size()));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clk_run   = 1'b1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        flush     = 1'b0;
        last_in_xfer = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming with out_ready held high: three-cycle accept-to-visible.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11; tick();
        chk("lat_1", 32'(out_valid), 32'd0);
        in_data   = 8'h22; tick();
        chk("lat_2", 32'(out_valid), 32'd0);
        in_data   = 8'h33; tick();
        chk("lat_3_valid", 32'(out_valid), 32'd1);
        chk("lat_3_data", 32'(out_data), 32'h11);
        chk("peak_count", 32'(count), 32'd3);
        in_data   = 8'h44; tick();
        chk("stream_22", 32'(out_data), 32'h22);
        in_valid  = 1'b0;
        tick();
        chk("stream_33", 32'(out_data), 32'h33);
        tick();
        chk("stream_44", 32'(out_data), 32'h44);
        tick();
        chk("empty_valid", 32'(out_valid), 32'd0);
        chk("empty_hold", 32'(out_data), 32'h44);

        // Asynchronous reset with the clock stopped and two words in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A; tick();
        in_data   = 8'h5B; tick();
        in_valid  = 1'b0;
        tick(); tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_data", 32'(out_data), 32'h5A);
        clk_run = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        clk_run = 1'b1;
        @(negedge clk);

        // Backpressure: only three of A0..A4 fit while out_ready is low.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(idx);
            #1;
            chk("bp_in_ready", 32'(in_ready), (c < 3) ? 32'd1 : 32'd0);
            tick();
            if (last_in_xfer) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (idx < 5 || exp_q.size() != 0); c++) begin
            in_valid = (idx < 5);
            in_data  = 8'hA0 + 8'(idx);
            tick();
            if (last_in_xfer) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 32'(idx), 32'd5);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Full pipe with simultaneous accept and emit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        chk("full_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hD0 + 8'(i);
            #1;
            chk("full_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("full_count_hold", 32'(count), 32'd3);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        chk("full_drained", 32'(exp_q.size()), 32'd0);

        // Flush with two words held and a producer still presenting.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hE0; tick();
        in_data   = 8'hE1; tick();
        flush     = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("flush_no_output", 32'(out_valid), 32'd0);
        end

`ifdef DFF_PIPE_STATS_EN
        // Stall counter: ten refused cycles on a full pipe, then flush.
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hF0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("stall_start", 32'(stall_cnt), 32'd0);
        repeat (10) tick();
        chk("stall_ten", 32'(stall_cnt), 32'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stall_flush", 32'(stall_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
